// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RISC-V core: sequences each instruction over a
// shared memory port and ALU, driving datapath selects and write strobes.
module multicycle_controller #(
  parameter bit ENABLE_JALR   = 1'b1,
  parameter bit ENABLE_LUI    = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUOp,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_EXECJALR = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_on_ready;
    logic       pcu_on_ready;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   mem_ready_eff;
  logic   mem_done;
  logic   unused_funct3;

  assign unused_funct3 = ^Funct3[2:1];

  // Per-state control word; anything not set here stays 0.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req      = 1'b1;
        c.ir_on_ready  = 1'b1;
        c.pcu_on_ready = 1'b1;
        c.result_src   = 2'b10;
        c.alu_src_b    = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S_EXECJALR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_LUI: begin
        c.alu_src_a = 2'b11;
        c.alu_src_b = 2'b01;
      end
      S_TRAP: c.illegal = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Memory handshake: an access is in flight while MemReq=1 and completes in the
  // cycle MemReady=1; until then the state and all strobes are held unchanged.
  assign mem_ready_eff = MEM_HANDSHAKE ? MemReady : 1'b1;
  // ctrl_q.mem_req stays 0 for the first cycle after reset, so FETCH cannot
  // complete before the memory request is actually visible.
  assign mem_done = mem_ready_eff & ctrl_q.mem_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = ENABLE_JALR ? S_EXECJALR : S_TRAP;
          OP_LUI:            state_d = ENABLE_LUI ? S_LUI : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_done) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_done) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_EXECJALR: state_d = S_JAL;
      S_LUI:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    ctrl_d = ctrl_for(state_d);
  end

  // Reset clears every strobe at once but leaves the FETCH selects on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= S_FETCH;
      ctrl_q              <= '0;
      ctrl_q.result_src   <= 2'b10;
      ctrl_q.alu_src_b    <= 2'b10;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    case (Op)
      OP_STORE: ImmSrc = 3'b001;
      OP_BR:    ImmSrc = 3'b010;
      OP_JAL:   ImmSrc = 3'b011;
      OP_LUI:   ImmSrc = 3'b100;
      default:  ImmSrc = 3'b000;
    endcase
  end

  assign MemReq    = ctrl_q.mem_req;
  assign MemWrite  = ctrl_q.mem_write;
  assign IRWrite   = ctrl_q.ir_on_ready & mem_ready_eff;
  assign PCWrite   = (ctrl_q.pcu_on_ready & mem_ready_eff) | ctrl_q.pc_update |
                     (ctrl_q.branch & (Zero ^ Funct3[0]));
  assign RegWrite  = ctrl_q.reg_write;
  assign AdrSrc    = ctrl_q.adr_src;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ALUOp     = ctrl_q.alu_op;
  assign Illegal   = ctrl_q.illegal;
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected control vectors are queued by
// the driver and popped/compared by an independent monitor on the falling edge.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  // {State, MemReq,MemWrite,IRWrite,PCWrite,RegWrite,AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal}
  localparam logic [18:0] E_RST   = {4'd0,  6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [18:0] E_FETCH = {4'd0,  6'b101100, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [18:0] E_FWAIT = {4'd0,  6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [18:0] E_DEC   = {4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
  localparam logic [18:0] E_MADR  = {4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [18:0] E_MRD   = {4'd3,  6'b100001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_MWB   = {4'd4,  6'b000010, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_MWR   = {4'd5,  6'b110001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_EXR   = {4'd6,  6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [18:0] E_EXI   = {4'd7,  6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
  localparam logic [18:0] E_AWB   = {4'd8,  6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_BR0   = {4'd9,  6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
  localparam logic [18:0] E_BR1   = {4'd9,  6'b000100, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
  localparam logic [18:0] E_JAL   = {4'd10, 6'b000100, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [18:0] E_JALR  = {4'd11, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [18:0] E_LUI   = {4'd12, 6'b000000, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0};
  localparam logic [18:0] E_TRAP  = {4'd13, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

  logic clk, rst;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic Zero, MemReady;

  logic       m_mreq, m_mwr, m_irw, m_pcw, m_rgw, m_adr, m_ill;
  logic [1:0] m_res, m_sa, m_sb, m_aop;
  logic [2:0] m_imm;
  logic [3:0] m_st;
  logic       n_mreq, n_mwr, n_irw, n_pcw, n_rgw, n_adr, n_ill;
  logic [1:0] n_res, n_sa, n_sb, n_aop;
  logic [2:0] n_imm;
  logic [3:0] n_st;

  logic [21:0] exp_q[$];
  string       name_q[$];
  logic        sel_nj;
  logic [6:0]  op_v;
  logic [2:0]  imm_v, f3_v;
  logic        zero_v;
  int          n_checks, n_fails;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct3(Funct3), .Zero(Zero), .MemReady(MemReady),
    .MemReq(m_mreq), .MemWrite(m_mwr), .IRWrite(m_irw), .PCWrite(m_pcw), .RegWrite(m_rgw),
    .AdrSrc(m_adr), .ResultSrc(m_res), .ALUSrcA(m_sa), .ALUSrcB(m_sb), .ImmSrc(m_imm),
    .ALUOp(m_aop), .Illegal(m_ill), .State(m_st)
  );

  multicycle_controller #(
    .ENABLE_JALR(1'b0), .ENABLE_LUI(1'b0), .MEM_HANDSHAKE(1'b0)
  ) dut_nj (
    .clk(clk), .rst(rst), .Op(Op), .Funct3(Funct3), .Zero(Zero), .MemReady(MemReady),
    .MemReq(n_mreq), .MemWrite(n_mwr), .IRWrite(n_irw), .PCWrite(n_pcw), .RegWrite(n_rgw),
    .AdrSrc(n_adr), .ResultSrc(n_res), .ALUSrcA(n_sa), .ALUSrcB(n_sb), .ImmSrc(n_imm),
    .ALUOp(n_aop), .Illegal(n_ill), .State(n_st)
  );

  wire [21:0] obs_m = {m_st, m_mreq, m_mwr, m_irw, m_pcw, m_rgw, m_adr,
                       m_res, m_sa, m_sb, m_aop, m_ill, m_imm};
  wire [21:0] obs_n = {n_st, n_mreq, n_mwr, n_irw, n_pcw, n_rgw, n_adr,
                       n_res, n_sa, n_sb, n_aop, n_ill, n_imm};

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = sel_nj ? obs_n : obs_m;
      n_checks++;
      if (a !== e) begin
        n_fails++;
        $display("FAIL %s: got %b expected %b (t=%0t)", nm, a, e, $time);
      end
    end
  end

  task automatic set_op(input logic [6:0] op, input logic [2:0] imm,
                        input logic [2:0] f3, input logic z);
    op_v   = op;
    imm_v  = imm;
    f3_v   = f3;
    zero_v = z;
  endtask

  task automatic drive_common();
    Op     = op_v;
    Funct3 = f3_v;
    Zero   = zero_v;
  endtask

  task automatic cyc(input logic [18:0] e, input logic rdy, input string nm);
    @(posedge clk);
    #1;
    drive_common();
    MemReady = rdy;
    exp_q.push_back({e, imm_v});
    name_q.push_back(nm);
  endtask

  task automatic rst_cyc(input string nm);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_common();
    MemReady = 1'b1;
    exp_q.push_back({E_RST, imm_v});
    name_q.push_back(nm);
  endtask

  task automatic rel_cyc(input string nm);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_common();
    MemReady = 1'b1;
    exp_q.push_back({E_RST, imm_v});
    name_q.push_back(nm);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    sel_nj   = 1'b0;
    rst      = 1'b0;
    MemReady = 1'b1;
    set_op(OP_R, 3'b000, 3'b000, 1'b0);
    drive_common();

    rst_cyc("reset_hold");
    rst_cyc("reset_hold");
    rel_cyc("release_no_memreq");

    cyc(E_FETCH, 1'b1, "add_fetch");
    cyc(E_DEC,   1'b1, "add_decode");
    cyc(E_EXR,   1'b1, "add_execr");
    cyc(E_AWB,   1'b1, "add_aluwb");

    set_op(OP_LOAD, 3'b000, 3'b010, 1'b0);
    cyc(E_FETCH, 1'b1, "ld_fetch");
    cyc(E_DEC,   1'b1, "ld_decode");
    cyc(E_MADR,  1'b1, "ld_memadr");
    cyc(E_MRD,   1'b0, "ld_memread_wait1");
    cyc(E_MRD,   1'b0, "ld_memread_wait2");
    cyc(E_MRD,   1'b1, "ld_memread_done");
    cyc(E_MWB,   1'b1, "ld_memwb");

    set_op(OP_STORE, 3'b001, 3'b010, 1'b0);
    cyc(E_FWAIT, 1'b0, "st_fetch_wait");
    cyc(E_FETCH, 1'b1, "st_fetch");
    cyc(E_DEC,   1'b1, "st_decode");
    cyc(E_MADR,  1'b1, "st_memadr");
    cyc(E_MWR,   1'b0, "st_memwrite_wait");
    cyc(E_MWR,   1'b1, "st_memwrite_done");

    set_op(OP_BR, 3'b010, 3'b000, 1'b1);
    cyc(E_FETCH, 1'b1, "beq_taken_fetch");
    cyc(E_DEC,   1'b1, "beq_taken_decode");
    cyc(E_BR1,   1'b1, "beq_taken_branch");
    set_op(OP_BR, 3'b010, 3'b001, 1'b1);
    cyc(E_FETCH, 1'b1, "bne_nt_fetch");
    cyc(E_DEC,   1'b1, "bne_nt_decode");
    cyc(E_BR0,   1'b1, "bne_nt_branch");
    set_op(OP_BR, 3'b010, 3'b001, 1'b0);
    cyc(E_FETCH, 1'b1, "bne_taken_fetch");
    cyc(E_DEC,   1'b1, "bne_taken_decode");
    cyc(E_BR1,   1'b1, "bne_taken_branch");
    set_op(OP_BR, 3'b010, 3'b000, 1'b0);
    cyc(E_FETCH, 1'b1, "beq_nt_fetch");
    cyc(E_DEC,   1'b1, "beq_nt_decode");
    cyc(E_BR0,   1'b1, "beq_nt_branch");

    set_op(OP_I, 3'b000, 3'b000, 1'b1);
    cyc(E_FETCH, 1'b1, "addi_fetch");
    cyc(E_DEC,   1'b1, "addi_decode");
    cyc(E_EXI,   1'b1, "addi_execi");
    cyc(E_AWB,   1'b1, "addi_aluwb");

    set_op(OP_JAL, 3'b011, 3'b000, 1'b0);
    cyc(E_FETCH, 1'b1, "jal_fetch");
    cyc(E_DEC,   1'b1, "jal_decode");
    cyc(E_JAL,   1'b1, "jal_jal");
    cyc(E_AWB,   1'b1, "jal_aluwb");

    set_op(OP_JALR, 3'b000, 3'b000, 1'b0);
    cyc(E_FETCH, 1'b1, "jalr_fetch");
    cyc(E_DEC,   1'b1, "jalr_decode");
    cyc(E_JALR,  1'b1, "jalr_execjalr");
    cyc(E_JAL,   1'b1, "jalr_jal");
    cyc(E_AWB,   1'b1, "jalr_aluwb");

    set_op(OP_LUI, 3'b100, 3'b000, 1'b0);
    cyc(E_FETCH, 1'b1, "lui_fetch");
    cyc(E_DEC,   1'b1, "lui_decode");
    cyc(E_LUI,   1'b1, "lui_lui");
    cyc(E_AWB,   1'b1, "lui_aluwb");

    set_op(OP_LOAD, 3'b000, 3'b000, 1'b0);
    cyc(E_FETCH, 1'b1, "abort_fetch");
    cyc(E_DEC,   1'b1, "abort_decode");
    cyc(E_MADR,  1'b1, "abort_memadr");
    cyc(E_MRD,   1'b0, "abort_memread_wait");
    rst_cyc("abort_reset");
    rel_cyc("abort_release");
    set_op(OP_R, 3'b000, 3'b000, 1'b0);
    cyc(E_FETCH, 1'b1, "post_abort_fetch");
    cyc(E_DEC,   1'b1, "post_abort_decode");

    set_op(OP_BAD, 3'b000, 3'b000, 1'b0);
    rst_cyc("bad_reset");
    rel_cyc("bad_release");
    cyc(E_FETCH, 1'b1, "bad_fetch");
    cyc(E_DEC,   1'b1, "bad_decode");
    for (int i = 0; i < 10; i++) cyc(E_TRAP, 1'b1, "trap_hold");
    rst_cyc("trap_reset");
    rel_cyc("trap_release");
    cyc(E_FETCH, 1'b1, "trap_cleared_fetch");

    @(negedge clk);
    #1;
    sel_nj = 1'b1;
    set_op(OP_JALR, 3'b000, 3'b000, 1'b0);
    rst_cyc("nj_reset");
    rel_cyc("nj_release");
    cyc(E_FETCH, 1'b0, "nj_fetch_ready_ignored");
    cyc(E_DEC,   1'b0, "nj_jalr_decode");
    for (int i = 0; i < 3; i++) cyc(E_TRAP, 1'b1, "nj_jalr_trap");
    set_op(OP_LUI, 3'b100, 3'b000, 1'b0);
    rst_cyc("nl_reset");
    rel_cyc("nl_release");
    cyc(E_FETCH, 1'b0, "nl_fetch");
    cyc(E_DEC,   1'b1, "nl_lui_decode");
    cyc(E_TRAP,  1'b1, "nl_lui_trap");

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multi-cycle RISC-V core, replacing the single-cycle main decoder. Each instruction is sequenced over 3–5+ cycles across one shared memory port and one shared ALU. Supports R, I-ALU, load, store, beq/bne, jal, jalr and lui, and stalls on a memory ready handshake. It drives datapath mux selects and write strobes; ALU function decode remains in the separate ALU decoder, fed by ALUOp.

## Interface
- ENABLE_JALR, 1, 1 = jalr legal; 0 = jalr traps
- ENABLE_LUI, 1, 1 = lui legal; 0 = lui traps
- MEM_HANDSHAKE, 1, 1 = memory states wait for MemReady; 0 = MemReady ignored, treated as 1
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- Op  in  7  opcode from instruction register
- Funct3  in  3  instr[14:12]; only bit 0 used (beq/bne)
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory access completes this cycle
- MemReq  out  1  memory access active
- MemWrite  out  1  store strobe
- IRWrite  out  1  load instruction/OldPC registers
- PCWrite  out  1  PC update
- RegWrite  out  1  register-file write
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = const 4
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- ALUOp  out  2  00 = add, 01 = sub/compare, 10 = funct decode
- Illegal  out  1  trap state reached
- State  out  4  current state, for debug

## Operation
- ImmSrc is combinational from Op in every state: store → 001, branch → 010, jal → 011, lui → 100, else 000.
- Opcodes: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111.
- Unlisted selects and strobes are 0 in each state.
- PCWrite = PCUpdate | (Branch & (Zero ^ Funct3[0])).
- States and transitions:
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00. IRWrite and PCUpdate asserted only when MemReady. Stay until MemReady, then → DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jal target → ALUOut).
    - → MEMADR for load/store; EXECR for R; EXECI for I-ALU; BRANCH for branch; JAL for jal; EXECJALR for jalr; LUI for lui.
    - Any other opcode, or a disabled one, → TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. → MEMREAD for load, MEMWRITE for store.
  - MEMREAD: MemReq=1, AdrSrc=1. Wait for MemReady, then → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. → FETCH.
  - MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1. MemWrite is held while waiting for MemReady, then → FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. → ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. → FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. → ALUWB, which writes OldPC+4.
  - EXECJALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (rs1+imm → ALUOut). → JAL.
  - LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00. → ALUWB.
  - TRAP: Illegal=1, all strobes 0. Held until reset.
- Op and Funct3 must be stable from DECODE to the end of the instruction; the IR is written only in FETCH.

## Timing
- Reset asynchronous: state → FETCH immediately.
- While rst=0: MemReq, MemWrite, IRWrite, PCWrite, RegWrite and Illegal are forced 0. Selects take their FETCH values.
- First MemReq is asserted in the cycle after rst deasserts.
- Zero-wait cycle counts: branch 3; R, I-ALU, store, jal and lui 4; load and jalr 5.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Strobes stay asserted and the state is held.
- Reset during any state, including a memory wait, aborts the instruction; no partial RegWrite or PCWrite follows.
- MemReady outside memory states is ignored.

## Test plan
- Reset: rst=0 with MemReady=1 → all strobes 0 and State=FETCH. Release rst → MemReq=1 on the next cycle.
- Add: Op=0110011, MemReady=1 → FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4, ALUOp=10 in cycle 3.
- Load with 2 wait states in MEMREAD: Op=0000011 → 7 cycles total, AdrSrc=1 for 3 cycles, RegWrite=1 with ResultSrc=01 once.
- Branch: Op=1100011. Funct3=000, Zero=1 → PCWrite=1 in BRANCH. Funct3=001, Zero=1 → PCWrite=0. Funct3=001, Zero=0 → PCWrite=1.
- jalr with ENABLE_JALR=1: Op=1100111 → DECODE, EXECJALR, JAL (PCWrite=1), ALUWB (RegWrite=1).
- Illegal: ENABLE_JALR=0 with Op=1100111, or Op=1111111 → TRAP with Illegal=1, held 10 cycles with no strobes. Reset clears it.
